cart_mapper: RTL and testbench

- Parametrised cartridge bank-switching mapper between the 6502 address bus and the cartridge ROM/RAM.
- Generalises the fixed 4 KB cartridge window to 1/2/4/8 banks of 4 KB using the standard F8/F6/F4-style hotspots.
- Optionally provides a 128-byte SuperChip RAM.
- Produces the widened ROM address and a RAM select/data for the top-level CPU data-in multiplexer.

---
 rtl/cart_mapper.sv | 102 ++++++++++
 tb/tb_cart_mapper.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cart_mapper.sv
// Cartridge bank-switching mapper: F8/F6/F4-style hotspot bank register,
// widened ROM address and optional 128-byte SuperChip RAM.
module cart_mapper #(
  parameter int          BANKS      = 4,
  parameter int          BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter logic [11:0] HOT_BASE   = 12'hFF6,
  parameter bit          SUPERCHIP  = 1'b0,
  parameter int          RESET_BANK = BANKS - 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_en_i,
  input  logic [12:0]         cpu_addr_i,
  input  logic                cpu_we_i,
  input  logic [7:0]          cpu_dat_i,
  output logic [11+BANK_W:0]  rom_addr_o,
  output logic                sc_sel_o,
  output logic [7:0]          sc_dat_o,
  output logic [BANK_W-1:0]   bank_o,
  input  logic                force_we_i,
  input  logic [BANK_W-1:0]   force_bank_i
);

  localparam logic [12:0]       HOT_END   = {1'b0, HOT_BASE} + 13'(BANKS);
  localparam logic [BANK_W-1:0] RESET_VAL = (BANKS == 1) ? '0 : BANK_W'(RESET_BANK);

  logic              rom_cs_s;
  logic [11:0]       off_s;
  logic [11:0]       hot_idx_s;
  logic              hit_s;
  logic              unused_idx_s;
  logic [BANK_W-1:0] bank_q, bank_d;

  assign rom_cs_s     = cpu_addr_i[12];
  assign off_s        = cpu_addr_i[11:0];
  assign hot_idx_s    = off_s - HOT_BASE;
  assign unused_idx_s = ^hot_idx_s;

  // Hotspot decode; a single-bank cartridge has no switching at all.
  always_comb begin
    hit_s = 1'b0;
    if (BANKS > 1) begin
      hit_s = cpu_en_i & rom_cs_s & (off_s >= HOT_BASE) & ({1'b0, off_s} < HOT_END);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Bank next-state: loader override beats a hotspot hit.
  always_comb begin
    bank_d = bank_q;
    if (BANKS == 1) begin
      bank_d = '0;
    end else if (force_we_i) begin
      bank_d = force_bank_i;
    end else if (hit_s) begin
      bank_d = hot_idx_s[BANK_W-1:0];
    end else begin
      bank_d = bank_q;
    end
  end

  // Bank register, the only state cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= RESET_VAL;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign rom_addr_o = {bank_q, off_s};
  assign bank_o     = bank_q;

  if (SUPERCHIP) begin : g_sc
    logic [7:0] mem_q [128];
    logic [7:0] rd_q;
    logic       wr_s;

    assign wr_s     = cpu_en_i & rom_cs_s & cpu_we_i & (off_s[11:7] == 5'd0);
    assign sc_sel_o = rom_cs_s & ~cpu_we_i & (off_s[11:7] == 5'd1);
    assign sc_dat_o = rd_q;

    // RAM write port at offsets 000-07F.
    always_ff @(posedge clk_i) begin
      if (wr_s) begin
        mem_q[off_s[6:0]] <= cpu_dat_i;
      end
    end

    // Read data lags the address by one clock; the CPU samples much later.
    always_ff @(posedge clk_i) begin
      rd_q <= mem_q[off_s[6:0]];
    end
  end else begin : g_no_sc
    logic unused_sc_s;
    assign unused_sc_s = ^{cpu_dat_i, cpu_we_i};
    assign sc_sel_o    = 1'b0;
    assign sc_dat_o    = 8'h00;
  end

endmodule

// File: tb/tb_cart_mapper.sv
// Scoreboard bench: a 4-bank SuperChip mapper and an 8-bank plain mapper share
// one CPU bus; a behavioural model queues expectations, a monitor compares.
module tb_cart_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [12:0] addr = 13'h0000;
  logic        we = 1'b0;
  logic [7:0]  dat = 8'h00;
  logic        f4 = 1'b0;
  logic [1:0]  fb4 = 2'd0;
  logic        f8 = 1'b0;
  logic [2:0]  fb8 = 3'd0;

  logic [13:0] rom4;
  logic        sel4;
  logic [7:0]  dat4;
  logic [1:0]  bank4;
  logic [14:0] rom8;
  logic        sel8;
  logic [7:0]  dat8;
  logic [2:0]  bank8;

  always #5 clk = ~clk;

  cart_mapper #(.BANKS(4), .HOT_BASE(12'hFF6), .SUPERCHIP(1'b1)) u4 (
    .clk_i(clk), .rst_i(rst), .cpu_en_i(en), .cpu_addr_i(addr), .cpu_we_i(we),
    .cpu_dat_i(dat), .rom_addr_o(rom4), .sc_sel_o(sel4), .sc_dat_o(dat4),
    .bank_o(bank4), .force_we_i(f4), .force_bank_i(fb4));

  cart_mapper #(.BANKS(8), .HOT_BASE(12'hFF4), .SUPERCHIP(1'b0)) u8 (
    .clk_i(clk), .rst_i(rst), .cpu_en_i(en), .cpu_addr_i(addr), .cpu_we_i(we),
    .cpu_dat_i(dat), .rom_addr_o(rom8), .sc_sel_o(sel8), .sc_dat_o(dat8),
    .bank_o(bank8), .force_we_i(f8), .force_bank_i(fb8));

  typedef struct {
    bit chk_b4; int b4; int r4;
    bit chk_b8; int b8; int r8;
    bit sel4;
    bit chk_d4; int d4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: bank numbers (-1 = unknown before first reset) and RAM image.
  int   m4 = -1;
  int   m8 = -1;
  int   mem [128];
  bit   memv [128];
  bit   pend_v = 1'b0;
  int   pend_d = 0;

  function automatic int next_bank(int cur, int n, int hb, int a, bit e, bit r, bit f, int fb);
    int off;
    off = a % 4096;
    if (r) return n - 1;
    if (f) return fb;
    if (e && a >= 4096 && off >= hb && off < hb + n) return off - hb;
    return cur;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input int a, input bit w, input int d, input bit e,
                     input bit r, input bit ff4, input int b4, input bit ff8, input int b8);
    exp_t x;
    int   off;
    addr = 13'(a); we = w; dat = 8'(d); en = e; rst = r;
    f4 = ff4; fb4 = 2'(b4); f8 = ff8; fb8 = 3'(b8);
    off = a % 4096;
    x.chk_b4 = (m4 >= 0); x.b4 = m4; x.r4 = m4 * 4096 + off;
    x.chk_b8 = (m8 >= 0); x.b8 = m8; x.r8 = m8 * 4096 + off;
    x.sel4   = (a >= 4096) && !w && off >= 128 && off < 256;
    x.chk_d4 = pend_v; x.d4 = pend_d;
    sb.push_back(x);
    pend_v = memv[off % 128];
    pend_d = mem[off % 128];
    if (e && a >= 4096 && w && off < 128) begin
      mem[off] = d;
      memv[off] = 1'b1;
    end
    m4 = next_bank(m4, 4, 'hFF6, a, e, r, ff4, b4);
    m8 = next_bank(m8, 8, 'hFF4, a, e, r, ff8, b8);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a);
    cyc(a, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(a, 1'b1, d, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic idle(input int a);
    cyc(a, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // Monitor: every cycle the DUTs present outputs, pop one expectation and compare.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("sel4", int'(sel4), int'(x.sel4));
      check("sel8", int'(sel8), 0);
      check("scdat8", int'(dat8), 0);
      if (x.chk_b4) begin
        check("bank4", int'(bank4), x.b4);
        check("rom4", int'(rom4), x.r4);
      end
      if (x.chk_b8) begin
        check("bank8", int'(bank8), x.b8);
        check("rom8", int'(rom8), x.r8);
      end
      if (x.chk_d4) check("scdat4", int'(dat4), x.d4);
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i] = 0;
      memv[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc('h0000, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    cyc('h0000, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    rd('h1000);
    // Basic hotspots on both mappers.
    rd('h1FF6); idle('h1000);
    rd('h1FF9); idle('h1000);
    wr('h1FF7, 'h00); idle('h1000);
    rd('h1FFA); idle('h1000);
    // Address held without the strobe must not switch.
    for (int i = 0; i < 16; i++) idle('h1FF8);
    rd('h1FF8);
    for (int i = 0; i < 4; i++) idle('h1FF8);
    // 8-bank sweep.
    for (int a = 'h1FF4; a <= 'h1FFB; a++) rd(a);
    idle('h1000);
    // Override beats a simultaneous hit; reset beats the override.
    cyc('h1FF5, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2, 1'b1, 5); idle('h1000);
    cyc('h1FF5, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 2); idle('h1000);
    // SuperChip ports.
    wr('h1005, 'hA5);
    rd('h1085); idle('h1085);
    wr('h1085, 'h11); idle('h1000);
    rd('h1005); idle('h1005);
    rd('h1085); idle('h1085);
    // Mirror below $1000 has no effect.
    rd('h0FF6); wr('h0005, 'h3C); rd('h1085); idle('h1085);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int  a, sel, d, b4, b8;
      bit  w, e, r, ff4, ff8;
      sel = $urandom_range(0, 3);
      if (sel == 0)      a = $urandom_range('h1FF0, 'h1FFF);
      else if (sel == 1) a = $urandom_range('h1000, 'h10FF);
      else if (sel == 2) a = $urandom_range('h0000, 'h00FF);
      else               a = $urandom_range(0, 'h1FFF);
      w   = 1'($urandom_range(0, 1));
      e   = 1'($urandom_range(0, 1));
      d   = $urandom_range(0, 255);
      r   = ($urandom_range(0, 99) == 0);
      ff4 = ($urandom_range(0, 29) == 0);
      ff8 = ($urandom_range(0, 29) == 0);
      b4  = $urandom_range(0, 3);
      b8  = $urandom_range(0, 7);
      if (r) e = 1'b0;
      cyc(a, w, d, e, r, ff4, b4, ff8, b8);
    end
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
